lisnoc_packet_injector: RTL
===========================

# lisnoc_packet_injector

Endpoint-side packet transmitter for a LISNoC mesh link. It accepts a packet request (destination, virtual channel, header bits, payload length) plus a stream of 32-bit payload words from the local tile. It serializes them into typed flits on a mesh input link using the per-virtual-channel valid/ready flit handshake. It sits between a tile's network adapter and the `linkN_in` side of a mesh.

## Interface

Parameters:
- `vchannels`, 1: number of virtual channels on the link.
- `VCW`, 1: width of the VC index on the request port.
- `LENW`, 4: width of the payload length field; max payload = 2^LENW-1 words.

Flit format is fixed at `FLIT_WIDTH` = 34:
- [33:32] type: 00 PAYLOAD, 01 HEAD, 10 TAIL, 11 SINGLE.
- Head/single flits: [31:27] dest, [26:0] header.
- Payload/tail flits: [31:0] data.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock.
  - `rst`  in  1  reset.
- Request channel:
  - `req_valid_i`  in  1  packet request valid.
  - `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
  - `req_dest_i`  in  5  destination node.
  - `req_vc_i`  in  VCW  VC index; a value ≥ `vchannels` maps to VC 0.
  - `req_len_i`  in  LENW  payload word count; 0 produces a SINGLE flit.
  - `req_hdr_i`  in  27  header bits.
- Payload channel:
  - `data_valid_i`  in  1  payload word valid.
  - `data_ready_o`  out  1  payload word accepted.
  - `data_i`  in  32  payload word.
- Link side:
  - `link_flit_o`  out  34  flit.
  - `link_valid_o`  out  vchannels  one-hot valid on the packet's VC.
  - `link_ready_i`  in  vchannels  per-VC ready from the mesh.
- Status:
  - `busy_o`  out  1  packet in progress or flit pending.
  - `pkt_done_o`  out  1  one-cycle pulse when the last flit of a packet is accepted.

## Operation

- Single output register holds `flit`, `vc`, and `ovalid`.
  - `link_valid_o` = `ovalid` ? (1 << `vc`) : 0.
- A flit is accepted when `ovalid && link_ready_i[vc]`; this is the `acc` condition.
- `free` = `!ovalid || acc`. The register may load a new flit only when `free`.
- FSM states: IDLE and PAYLOAD.
- IDLE:
  - `req_ready_o` = `free`.
  - On request handshake, load the HEAD flit, or a SINGLE flit if `req_len_i` = 0.
  - Latch `vc` from `req_vc_i` and set `rem` = `req_len_i`.
  - Go to PAYLOAD if `req_len_i` ≠ 0, otherwise stay in IDLE.
- PAYLOAD:
  - `req_ready_o` = 0; `data_ready_o` = `free`.
  - On data handshake, load a flit of type TAIL if `rem` = 1, else PAYLOAD, with data = `data_i`.
  - Decrement `rem`; when `rem` was 1, go to IDLE.
- `data_ready_o` = 0 in IDLE. Payload words presented in IDLE are not consumed.
- `rem` is LENW bits wide and never wraps: decrement happens only in PAYLOAD, where `rem` ≥ 1.
- Other outputs:
  - `pkt_done_o` = `acc` && flit type ∈ {TAIL, SINGLE}; combinational.
  - `busy_o` = (state ≠ IDLE) || `ovalid`.
- VC is held for the whole packet. Interleaving packets on different VCs is not supported; packets are sent strictly in order.
- Back-pressure: while `link_ready_i[vc]` = 0, `link_flit_o` and `link_valid_o` are held stable. Readiness of other VCs is ignored.

## Timing

- Reset (`rst` low) asynchronously forces:
  - state IDLE, `ovalid` 0, `rem` 0, `vc` 0, `flit` 0.
  - `link_valid_o` 0, `link_flit_o` 0, `busy_o` 0, `pkt_done_o` 0.
  - `req_ready_o` and `data_ready_o` are gated to 0 while `rst` is low.
- After reset release, `req_ready_o` = 1 in the first cycle.
- Latency: a handshake in cycle N gives `link_valid_o` high in cycle N+1 with the corresponding flit.
- Throughput: one flit per cycle with ready held high.
  - Packet of length L occupies L+1 consecutive cycles.
  - The next packet's head follows the tail with no bubble, since acceptance and load happen in the same cycle.
- Simultaneous `acc` and new load: the register takes the new flit and `ovalid` stays 1.
- Reset mid-packet drops the remainder. The mesh may receive a truncated packet, which is the upstream's responsibility.

## Test plan

- **Single flit.** Reset, then request dest=5, vc=0, len=0, hdr=27'h0ABCDE with ready=1.
  - Next cycle: flit = {2'b11, 5'd5, 27'h0ABCDE}, `link_valid_o`=1.
  - `pkt_done_o` pulses in that cycle; `busy_o` then returns to 0.
- **Three-word packet.** dest=3, len=3, data 0x11111111/0x22222222/0x33333333 always valid, ready=1.
  - Types HEAD, PAYLOAD, PAYLOAD, TAIL in 4 consecutive cycles with correct data.
  - `pkt_done_o` pulses only with the TAIL.
- **Back-pressure.** Same packet with `link_ready_i` low for 3 cycles after the head appears.
  - Head is held unchanged for 4 cycles and `data_ready_o`=0 throughout.
  - No word is lost or duplicated.
- **VC selection.** `vchannels`=2, `VCW`=1, vc=1, `link_ready_i`=2'b01.
  - `link_valid_o`=2'b10 and the flit stalls.
  - Raising bit 1 releases the packet; out-of-range vc (`VCW`=2, vc=3) is driven on VC 0.
- **Back-to-back.** Two len=1 packets requested continuously.
  - Output sequence is HEAD, TAIL, HEAD, TAIL in 4 consecutive cycles.
  - `req_ready_o` is low during PAYLOAD.
- **Reset mid-packet.** Assert `rst` low after the head of a len=4 packet.
  - All outputs are zero immediately.
  - After release, a new len=0 request is accepted in the first cycle.

Source files
------------

// File: rtl/lisnoc_packet_injector_if.sv
// Request, payload and link-side signals of the LISNoC packet injector.
// master = tile adapter / mesh environment, slave = the injector itself.
interface lisnoc_packet_injector_if #(
    parameter int vchannels = 1,
    parameter int VCW       = 1,
    parameter int LENW      = 4
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [4:0]           req_dest_i;
    logic [VCW-1:0]       req_vc_i;
    logic [LENW-1:0]      req_len_i;
    logic [26:0]          req_hdr_i;

    logic                 data_valid_i;
    logic                 data_ready_o;
    logic [31:0]          data_i;

    logic [33:0]          link_flit_o;
    logic [vchannels-1:0] link_valid_o;
    logic [vchannels-1:0] link_ready_i;

    modport master (
        output req_valid_i, req_dest_i, req_vc_i, req_len_i, req_hdr_i,
        output data_valid_i, data_i,
        output link_ready_i,
        input  req_ready_o, data_ready_o, link_flit_o, link_valid_o
    );

    modport slave (
        input  req_valid_i, req_dest_i, req_vc_i, req_len_i, req_hdr_i,
        input  data_valid_i, data_i,
        input  link_ready_i,
        output req_ready_o, data_ready_o, link_flit_o, link_valid_o
    );
endinterface

// File: rtl/lisnoc_packet_injector.sv
// Serializes a packet request plus payload words into HEAD/PAYLOAD/TAIL
// (or SINGLE) flits on one virtual channel of a LISNoC mesh input link.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a request; output register may still drain
// ST_PAYLOAD | head sent, streaming rem_q remaining payload words
module lisnoc_packet_injector #(
    parameter int vchannels = 1,
    parameter int VCW       = 1,
    parameter int LENW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    lisnoc_packet_injector_if.slave bus,
    output logic                    busy_o,
    output logic                    pkt_done_o
);
    localparam int FLIT_WIDTH = 34;
    localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
    localparam logic [1:0] TYPE_HEAD    = 2'b01;
    localparam logic [1:0] TYPE_TAIL    = 2'b10;
    localparam logic [1:0] TYPE_SINGLE  = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    state_t                state_q, state_d;
    logic [FLIT_WIDTH-1:0] flit_q, flit_d;
    logic [VCW-1:0]        vc_q, vc_d;
    logic [LENW-1:0]       rem_q, rem_d;
    logic                  ovalid_q, ovalid_d;

    logic [vchannels-1:0]  link_valid;
    logic [VCW-1:0]        req_vc_map;
    logic                  acc;
    logic                  free;
    logic                  last_word;
    logic                  req_ready;
    logic                  data_ready;

    always_comb begin
        link_valid = '0;
        for (int i = 0; i < vchannels; i++) begin
            if (ovalid_q && (vc_q == VCW'(i))) begin
                link_valid[i] = 1'b1;
            end
        end
    end

    // Only the ready of the packet's own VC matters; link_valid is one-hot.
    assign acc        = |(link_valid & bus.link_ready_i);
    assign free       = !ovalid_q || acc;
    assign last_word  = (rem_q == LENW'(1));
    assign req_vc_map = (int'(bus.req_vc_i) < vchannels) ? bus.req_vc_i : '0;

    always_comb begin
        state_d    = state_q;
        flit_d     = flit_q;
        vc_d       = vc_q;
        rem_d      = rem_q;
        ovalid_d   = ovalid_q && !acc;
        req_ready  = 1'b0;
        data_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = free && rst;
                if (req_ready && bus.req_valid_i) begin
                    flit_d   = {(bus.req_len_i == '0) ? TYPE_SINGLE : TYPE_HEAD,
                                bus.req_dest_i, bus.req_hdr_i};
                    ovalid_d = 1'b1;
                    vc_d     = req_vc_map;
                    rem_d    = bus.req_len_i;
                    if (bus.req_len_i != '0) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                data_ready = free && rst;
                if (data_ready && bus.data_valid_i) begin
                    flit_d   = {last_word ? TYPE_TAIL : TYPE_PAYLOAD, bus.data_i};
                    ovalid_d = 1'b1;
                    rem_d    = rem_q - LENW'(1);
                    if (last_word) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            flit_q   <= '0;
            vc_q     <= '0;
            rem_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flit_q   <= flit_d;
            vc_q     <= vc_d;
            rem_q    <= rem_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.data_ready_o = data_ready;
    assign bus.link_flit_o  = flit_q;
    assign bus.link_valid_o = link_valid;
    // TAIL and SINGLE both have the top type bit set.
    assign pkt_done_o       = acc && flit_q[FLIT_WIDTH-1];
    assign busy_o           = (state_q != ST_IDLE) || ovalid_q;
endmodule
